// File: rtl/int16_div_pkg.sv
// Shared types and constants for the sequential 16-bit restoring divider.
package int16_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int          DIV_STEPS = 16;
  localparam logic [15:0] DIV0_QUOT = 16'hFFFF;

endpackage

// File: rtl/int16_div_step.sv
// One combinational radix-2 restoring step: shift in a dividend bit, trial
// subtract the divisor, keep the difference when it does not borrow.
module int16_div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // The partial remainder is always below the divisor, so the shifted value
  // fits in WIDTH+1 bits and diff's MSB is a clean borrow flag.
  always_comb begin
    shifted = {rem_in, dvd_bit};
    diff    = shifted - {1'b0, divisor};
    q_bit   = ~diff[WIDTH];
    rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/int16_div_seq.sv
// Sequential 16-cycle restoring divider with valid/ready handshakes.
// Define SIGNED_DIV_EN to add the signed_op port and signed (truncating) division.
module int16_div_seq
  import int16_div_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef SIGNED_DIV_EN
  input  logic             signed_op,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  div_state_t       state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] work_q, work_d;   // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH-1:0] prem_q, prem_d;
  logic             dz_q, dz_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic             signed_sel;
  logic             dvd_neg, dsr_neg;
  logic [WIDTH-1:0] step_rem;
  logic             step_qbit;
  logic [WIDTH-1:0] q_fin;

  int16_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (prem_q),
    .dvd_bit (work_q[WIDTH-1]),
    .divisor (dsr_q),
    .rem_out (step_rem),
    .q_bit   (step_qbit)
  );

`ifdef SIGNED_DIV_EN
  assign signed_sel = signed_op;
`else
  assign signed_sel = 1'b0;
`endif

  assign dvd_neg = signed_sel & dividend[WIDTH-1];
  assign dsr_neg = signed_sel & divisor[WIDTH-1];
  assign q_fin   = {work_q[WIDTH-2:0], step_qbit};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    dsr_d   = dsr_q;
    prem_d  = prem_q;
    dz_d    = dz_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = BUSY;
          cnt_d   = 5'd0;
          prem_d  = '0;
          dz_d    = (divisor == '0);
          qneg_d  = dvd_neg ^ dsr_neg;
          rneg_d  = dvd_neg;
          dsr_d   = dsr_neg ? ({WIDTH{1'b0}} - divisor) : divisor;
          // Divide-by-zero keeps the raw dividend so it can be returned as-is.
          if (dvd_neg && (divisor != '0)) work_d = {WIDTH{1'b0}} - dividend;
          else                            work_d = dividend;
        end
      end
      BUSY: begin
        if (dz_q) begin
          state_d = DONE;
          quot_d  = DIV0_QUOT;
          rem_d   = work_q;
          dbz_d   = 1'b1;
        end else begin
          work_d = q_fin;
          prem_d = step_rem;
          cnt_d  = cnt_q + 5'd1;
          if (cnt_q == 5'(DIV_STEPS - 1)) begin
            state_d = DONE;
            cnt_d   = 5'd0;
            quot_d  = qneg_q ? ({WIDTH{1'b0}} - q_fin) : q_fin;
            rem_d   = rneg_q ? ({WIDTH{1'b0}} - step_rem) : step_rem;
            dbz_d   = 1'b0;
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      work_q  <= '0;
      dsr_q   <= '0;
      prem_q  <= '0;
      dz_q    <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      dsr_q   <= dsr_d;
      prem_q  <= prem_d;
      dz_q    <= dz_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_int16_div_seq.sv
// Directed self-checking bench for int16_div_seq; signed cases and the random
// golden-model sweep build only when SIGNED_DIV_EN is defined.
module tb_int16_div_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] dividend = '0;
  logic [15:0] divisor = '0;
`ifdef SIGNED_DIV_EN
  logic        signed_op = 1'b0;
`endif
  logic        in_ready;
  logic        out_valid;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  int pass_cnt = 0;
  int total_cnt = 0;

  int16_div_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
`ifdef SIGNED_DIV_EN
    .signed_op   (signed_op),
`endif
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Launch one operation and wait for out_valid; lat = cycles from acceptance, -1 on timeout.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = ~a;
    divisor  = ~b;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) lat = -1;
    $display("op %h / %h -> q=%h r=%h dbz=%0d lat=%0d", a, b, quotient, remainder, div_by_zero, lat);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if ({in_ready, out_valid, quotient, remainder, div_by_zero} !== {1'b1, 1'b0, 16'h0, 16'h0, 1'b0}) begin
      $display("FAIL reset_state: got rdy=%0d vld=%0d q=%h r=%h dbz=%0d, want rdy=1 vld=0 q=0 r=0 dbz=0",
               in_ready, out_valid, quotient, remainder, div_by_zero);
    end else pass_cnt++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat;
    run_op(16'd100, 16'd7, lat);
    total_cnt++;
    if (lat !== 16) $display("FAIL basic_latency: got %0d, want 16", lat);
    else pass_cnt++;
    total_cnt++;
    if ({quotient, remainder, div_by_zero} !== {16'd14, 16'd2, 1'b0})
      $display("FAIL basic_100_7: got q=%0d r=%0d dbz=%0d, want q=14 r=2 dbz=0", quotient, remainder, div_by_zero);
    else pass_cnt++;
    consume();
    total_cnt++;
    if ({in_ready, out_valid} !== 2'b10)
      $display("FAIL basic_release: got rdy=%0d vld=%0d, want rdy=1 vld=0", in_ready, out_valid);
    else pass_cnt++;
  endtask

  task automatic test_vectors();
    logic [63:0] vecs [9];
    logic [63:0] v;
    int lat;
    vecs = '{
      {16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000},
      {16'd1000, 16'd3,    16'd333,  16'd1},
      {16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000},
      {16'h1234, 16'h8000, 16'h0000, 16'h1234},
      {16'h0000, 16'h0005, 16'h0000, 16'h0000},
      {16'h0007, 16'h0009, 16'h0000, 16'h0007},
      {16'hFFFE, 16'hFFFF, 16'h0000, 16'hFFFE},
      {16'hEA60, 16'h00FF, 16'h00EB, 16'h004B},
      {16'h8000, 16'h0002, 16'h4000, 16'h0000}
    };
    for (int i = 0; i < 9; i++) begin
      v = vecs[i];
      run_op(v[63:48], v[47:32], lat);
      total_cnt++;
      if ({lat == 16, quotient, remainder, div_by_zero} !== {1'b1, v[31:16], v[15:0], 1'b0})
        $display("FAIL vector_%0d: got q=%h r=%h dbz=%0d lat=%0d, want q=%h r=%h dbz=0 lat=16",
                 i, quotient, remainder, div_by_zero, lat, v[31:16], v[15:0]);
      else pass_cnt++;
      consume();
    end
  endtask

  task automatic test_div_zero();
    int lat;
    run_op(16'd5, 16'd0, lat);
    total_cnt++;
    if (lat !== 1) $display("FAIL div0_latency: got %0d, want 1", lat);
    else pass_cnt++;
    total_cnt++;
    if ({quotient, remainder, div_by_zero} !== {16'hFFFF, 16'd5, 1'b1})
      $display("FAIL div0_5: got q=%h r=%h dbz=%0d, want q=ffff r=0005 dbz=1", quotient, remainder, div_by_zero);
    else pass_cnt++;
    consume();
    run_op(16'h1234, 16'd0, lat);
    total_cnt++;
    if ({lat == 1, quotient, remainder, div_by_zero} !== {1'b1, 16'hFFFF, 16'h1234, 1'b1})
      $display("FAIL div0_1234: got q=%h r=%h dbz=%0d lat=%0d, want q=ffff r=1234 dbz=1 lat=1",
               quotient, remainder, div_by_zero, lat);
    else pass_cnt++;
    consume();
  endtask

  task automatic test_backpressure();
    int lat;
    int seen;
    run_op(16'd1000, 16'd3, lat);
    total_cnt++;
    if ({lat == 16, quotient, remainder, div_by_zero} !== {1'b1, 16'd333, 16'd1, 1'b0})
      $display("FAIL bp_result: got q=%0d r=%0d dbz=%0d lat=%0d, want q=333 r=1 dbz=0 lat=16",
               quotient, remainder, div_by_zero, lat);
    else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        dividend = 16'd50;
        divisor  = 16'd5;
        in_valid = 1'b1;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      total_cnt++;
      if ({out_valid, in_ready, quotient, remainder, div_by_zero} !== {1'b1, 1'b0, 16'd333, 16'd1, 1'b0})
        $display("FAIL bp_hold_%0d: got vld=%0d rdy=%0d q=%0d r=%0d dbz=%0d, want vld=1 rdy=0 q=333 r=1 dbz=0",
                 i, out_valid, in_ready, quotient, remainder, div_by_zero);
      else pass_cnt++;
    end
    consume();
    total_cnt++;
    if ({in_ready, out_valid} !== 2'b10)
      $display("FAIL bp_release: got rdy=%0d vld=%0d, want rdy=1 vld=0", in_ready, out_valid);
    else pass_cnt++;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    total_cnt++;
    if (seen !== 0) $display("FAIL bp_extra_result: got %0d valid cycles, want 0", seen);
    else pass_cnt++;
  endtask

  task automatic test_reset_abort();
    int lat;
    int seen;
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    dividend = 16'd200;
    divisor  = 16'd7;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({in_ready, out_valid, quotient, remainder, div_by_zero} !== {1'b1, 1'b0, 16'h0, 16'h0, 1'b0})
      $display("FAIL abort_reset: got rdy=%0d vld=%0d q=%h r=%h dbz=%0d, want rdy=1 vld=0 q=0 r=0 dbz=0",
               in_ready, out_valid, quotient, remainder, div_by_zero);
    else pass_cnt++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    total_cnt++;
    if (seen !== 0) $display("FAIL abort_no_result: got %0d valid cycles, want 0", seen);
    else pass_cnt++;
    run_op(16'd9, 16'd3, lat);
    total_cnt++;
    if ({lat == 16, quotient, remainder, div_by_zero} !== {1'b1, 16'd3, 16'd0, 1'b0})
      $display("FAIL abort_then_9_3: got q=%0d r=%0d dbz=%0d lat=%0d, want q=3 r=0 dbz=0 lat=16",
               quotient, remainder, div_by_zero, lat);
    else pass_cnt++;
    consume();
  endtask

`ifdef SIGNED_DIV_EN
  function automatic logic [32:0] golden(input logic [15:0] a, input logic [15:0] b, input logic s);
    int sq;
    int sr;
    logic [15:0] uq;
    logic [15:0] ur;
    if (b == 16'h0) return {1'b1, 16'hFFFF, a};
    if (!s) begin
      uq = a / b;
      ur = a % b;
      return {1'b0, uq, ur};
    end
    sq = int'($signed(a)) / int'($signed(b));
    sr = int'($signed(a)) % int'($signed(b));
    return {1'b0, sq[15:0], sr[15:0]};
  endfunction

  task automatic test_signed();
    logic [64:0] vecs [5];
    logic [64:0] v;
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic [32:0] exp_v;
    int lat;
    int bad;
    vecs = '{
      {16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0},
      {16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0},
      {16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001, 1'b0},
      {16'hFFF9, 16'hFFFE, 16'h0003, 16'hFFFF, 1'b0},
      {16'hFFF9, 16'h0000, 16'hFFFF, 16'hFFF9, 1'b1}
    };
    signed_op = 1'b1;
    for (int i = 0; i < 5; i++) begin
      v = vecs[i];
      run_op(v[64:49], v[48:33], lat);
      total_cnt++;
      if ({quotient, remainder, div_by_zero} !== v[32:0])
        $display("FAIL signed_%0d: got q=%h r=%h dbz=%0d, want q=%h r=%h dbz=%0d",
                 i, quotient, remainder, div_by_zero, v[32:17], v[16:1], v[0]);
      else pass_cnt++;
      consume();
    end
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom);
      b = (i % 50 == 0) ? 16'h0 : 16'($urandom);
      if (i % 7 == 0) b = 16'($urandom_range(1, 15));
      s = 1'($urandom);
      signed_op = s;
      exp_v = golden(a, b, s);
      run_op(a, b, lat);
      total_cnt++;
      if ({div_by_zero, quotient, remainder} !== exp_v ||
          lat !== ((b == 16'h0) ? 1 : 16)) begin
        bad++;
        $display("FAIL random_%0d: %h/%h s=%0d got q=%h r=%h dbz=%0d lat=%0d, want q=%h r=%h dbz=%0d",
                 i, a, b, s, quotient, remainder, div_by_zero, lat, exp_v[31:16], exp_v[15:0], exp_v[32]);
      end else pass_cnt++;
      consume();
    end
    signed_op = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_div_zero();
    test_backpressure();
    test_reset_abort();
`ifdef SIGNED_DIV_EN
    test_signed();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
